panel_loader: RTL and testbench
===============================

Name: panel_loader

Overview:
- Synthesizable successor to the bench-side memory fill sequence. Consumes a PAL binary object stream one byte per handshake and assembles WORD_W-bit words.
- Drives the Top front-panel inputs (sw, Load_PC, Deposit, run switch) with programmable hold timing.
- Finishes by loading START_PC and raising run.
- Sits between a byte source (UART or bench) and Top's panel inputs, replacing hand-timed switch toggling.

Parameters:
- WORD_W, 12, memory/PC word width; must be even; HALF_W = WORD_W/2 bits per object byte.
- HOLD_CYC, 10, clk cycles for each panel phase (setup, strobe, release); >= 1.
- START_PC, 12'o200, PC loaded after the stream ends, before run (width WORD_W).
- CNT_W, 16, width of the words_loaded counter.

Ports:
- clk, in, 1, system clock.
- btnCpuReset, in, 1, asynchronous active-low reset.
- byte_valid, in, 1, source has a byte.
- byte_data, in, 8, object byte.
- byte_last, in, 1, qualifies the final byte of the stream (sampled with byte_valid).
- byte_ready, out, 1, loader accepts a byte this cycle.
- sw, out, WORD_W, panel switch value.
- load_pc, out, 1, panel Load_PC.
- deposit, out, 1, panel Deposit.
- run, out, 1, panel run switch (sw[12] equivalent).
- busy, out, 1, a sequence is in progress.
- done, out, 1, load completed and run asserted.
- error, out, 1, framing error latched.
- words_loaded, out, CNT_W, deposits performed since reset.

Behaviour:
- Reset (async, active-low): every output is 0; state IDLE; counters and holding registers cleared. Reset mid-operation aborts immediately, with strobes low on the same edge.
- Transfer happens on a rising edge with byte_valid && byte_ready. byte_ready=1 only in GET_HI and GET_LO; it is combinational from state only, never from byte_valid.
- Byte classes:
  - bit7=1: leader/trailer; discarded in GET_HI.
  - bit6=1: origin high half.
  - bit6=0: data high half.
  - Low half byte: bits[HALF_W-1:0] only.
- Word assembly: word = {hi[HALF_W-1:0], lo[HALF_W-1:0]}. For WORD_W > 12 the upper byte bits are zero-extended into HALF_W.
- States: IDLE, GET_HI, GET_LO, SETUP, STROBE, RELEASE, LAST_SETUP, LAST_STROBE, LAST_RELEASE, RUN_WAIT, DONE, ERROR.
- Transitions:
  - IDLE -> GET_HI on the first cycle after reset release; busy=1 from then until DONE/ERROR.
  - GET_HI:
    - Leader byte: stay; if byte_last, go to LAST_SETUP.
    - Else latch hi and the origin flag; byte_last -> ERROR; otherwise -> GET_LO.
  - GET_LO: bit7 or bit6 set -> ERROR. Else latch lo, remember byte_last, -> SETUP.
  - SETUP: sw=word for HOLD_CYC cycles -> STROBE.
  - STROBE: assert load_pc (origin) or deposit (data) for exactly HOLD_CYC cycles; sw held -> RELEASE.
  - RELEASE: strobe low HOLD_CYC cycles, sw held. On exit, deposit increments words_loaded (saturating at all-ones). Then -> LAST_SETUP if stream ended, else GET_HI.
  - LAST_*: same three phases with sw=START_PC and load_pc.
  - RUN_WAIT: HOLD_CYC cycles -> DONE.
  - DONE: run=1, done=1, busy=0; sticky until reset; ignores bytes.
  - ERROR: error=1, busy=0, strobes low, run never asserted; sticky until reset.
- load_pc and deposit are never high simultaneously, and never high in the same cycle sw changes.
- Timing:
  - Per word: 3*HOLD_CYC cycles from the first SETUP cycle to the next GET_HI.
  - Start sequence: 4*HOLD_CYC cycles from the first LAST_SETUP cycle to run rising.
- A single phase counter of width $clog2(HOLD_CYC+1) is reused by all timed states.

Decomposition:
- Add to CPU_Definitions.pkg: loader_state_t enum; byte-class constants LEADER_BIT=7, ORIGIN_BIT=6. The word type is already there.
- One sub-module: panel_strobe_timer. It owns the phase counter and the setup/strobe/release sequencing for one panel action, with a start/kind input and a finished pulse. The FSM instantiates it once and reuses it for data, origin and START_PC actions.

Test Plan:
- Bytes 0x80,0x80, 0x42,0x00, 0x3F,0x3F(last) ->
  - load_pc with sw=0200;
  - deposit with sw=7777;
  - load_pc with sw=0200 (START_PC);
  - run=1, done=1, words_loaded=1.
- HOLD_CYC=10, one data pair: deposit high exactly 10 cycles; sw stable 30 cycles; next byte_ready 30 cycles after the first SETUP cycle.
- Low byte 0x45 after hi 0x01 -> error=1, no deposit pulse, run stays 0, byte_ready stays 0.
- btnCpuReset low during STROBE with deposit=1 -> deposit=0 asynchronously; all outputs 0; a subsequent stream loads normally.
- Stream of 0x80 only (last on third) -> no deposits; START_PC load then run=1, words_loaded=0.
- HOLD_CYC=1, WORD_W=12, 3 data pairs with byte_valid toggling every other cycle -> words_loaded=3, no lost or duplicated words, no overlapping strobes.

Source files
------------

// File: rtl/panel_loader_pkg.sv
// Shared types and constants for the front-panel object loader.
package panel_loader_pkg;

   // Byte-class bits of a PAL binary object byte
   localparam int unsigned LEADER_BIT = 7;
   localparam int unsigned ORIGIN_BIT = 6;

   typedef enum logic [3:0] {
      IDLE,
      GET_HI,
      GET_LO,
      SETUP,
      STROBE,
      RELEASE,
      LAST_SETUP,
      LAST_STROBE,
      LAST_RELEASE,
      RUN_WAIT,
      DONE,
      ERROR
   } loader_state_t;

   // Which panel action the strobe timer is sequencing
   typedef enum logic [1:0] {
      ACT_DEPOSIT,
      ACT_LOAD_PC,
      ACT_WAIT
   } action_kind_t;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_SETUP,
      PH_STROBE,
      PH_RELEASE,
      PH_WAIT
   } timer_phase_t;

endpackage

// File: rtl/panel_loader_if.sv
// Byte-stream handshake between an object-byte source and the loader.
interface panel_loader_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_last;
   logic       byte_ready;

   modport master (output byte_valid, output byte_data, output byte_last, input byte_ready);
   modport slave  (input byte_valid, input byte_data, input byte_last, output byte_ready);
endinterface

// File: rtl/panel_loader_strobe_timer.sv
// Setup/strobe/release sequencer for one panel action, plus a single-phase
// wait; owns the one phase counter shared by every timed loader state.
module panel_strobe_timer
   import panel_loader_pkg::*;
#(
   parameter int unsigned HOLD_CYC = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  action_kind_t kind,
   output logic         phase_end,
   output logic         finished,
   output logic         load_pc,
   output logic         deposit
);

   localparam int unsigned PW = $clog2(HOLD_CYC + 1);
   localparam logic [PW-1:0] LAST_CNT = PW'(HOLD_CYC - 1);

   timer_phase_t  phase_q, phase_d;
   action_kind_t  kind_q, kind_d;
   logic [PW-1:0] cnt_q, cnt_d;

   assign phase_end = (phase_q != PH_IDLE) && (cnt_q == LAST_CNT);
   assign finished  = phase_end && ((phase_q == PH_RELEASE) || (phase_q == PH_WAIT));
   assign load_pc   = (phase_q == PH_STROBE) && (kind_q == ACT_LOAD_PC);
   assign deposit   = (phase_q == PH_STROBE) && (kind_q == ACT_DEPOSIT);

   // Phase sequencing; a new start overrides the tail of a finishing action
   always_comb begin
      phase_d = phase_q;
      kind_d  = kind_q;
      cnt_d   = cnt_q;
      if (start) begin
         kind_d  = kind;
         cnt_d   = '0;
         phase_d = (kind == ACT_WAIT) ? PH_WAIT : PH_SETUP;
      end else if (phase_end) begin
         cnt_d = '0;
         case (phase_q)
            PH_SETUP:  phase_d = PH_STROBE;
            PH_STROBE: phase_d = PH_RELEASE;
            default:   phase_d = PH_IDLE;
         endcase
      end else if (phase_q != PH_IDLE) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Timer state register; reset drops any strobe immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_IDLE;
         kind_q  <= ACT_DEPOSIT;
         cnt_q   <= '0;
      end else begin
         phase_q <= phase_d;
         kind_q  <= kind_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/panel_loader.sv
// Assembles PAL object bytes into words and replays them on the Top front
// panel (origin -> Load_PC, data -> Deposit), then loads START_PC and runs.
module panel_loader
   import panel_loader_pkg::*;
#(
   parameter int unsigned       WORD_W   = 12,
   parameter int unsigned       HOLD_CYC = 10,
   parameter logic [WORD_W-1:0] START_PC = 12'o200,
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              btnCpuReset,
   panel_loader_if.slave     src,
   output logic [WORD_W-1:0] sw,
   output logic              load_pc,
   output logic              deposit,
   output logic              run,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  words_loaded
);

   localparam int unsigned HALF_W = WORD_W / 2;

   loader_state_t     state_q, state_d;
   logic [HALF_W-1:0] hi_q, lo_q, byte_half;
   logic              origin_q, last_q;
   logic [CNT_W-1:0]  words_q;
   logic              take, is_leader, is_origin;
   logic              latch_hi, latch_lo, bump;
   logic              t_start, t_phase_end, t_finished;
   action_kind_t      t_kind;

   assign src.byte_ready = (state_q == GET_HI) || (state_q == GET_LO);
   assign take           = src.byte_valid && src.byte_ready;
   assign is_leader      = src.byte_data[LEADER_BIT];
   assign is_origin      = src.byte_data[ORIGIN_BIT];
   assign byte_half      = HALF_W'(src.byte_data);
   assign words_loaded   = words_q;

   panel_strobe_timer #(.HOLD_CYC(HOLD_CYC)) u_timer (
      .clk       (clk),
      .rst_n     (btnCpuReset),
      .start     (t_start),
      .kind      (t_kind),
      .phase_end (t_phase_end),
      .finished  (t_finished),
      .load_pc   (load_pc),
      .deposit   (deposit)
   );

   // Next-state logic; the timer is started on the edge that enters a timed state
   always_comb begin
      state_d  = state_q;
      t_start  = 1'b0;
      t_kind   = ACT_DEPOSIT;
      latch_hi = 1'b0;
      latch_lo = 1'b0;
      bump     = 1'b0;
      case (state_q)
         IDLE: state_d = GET_HI;
         GET_HI: if (take) begin
            if (is_leader) begin
               if (src.byte_last) begin
                  state_d = LAST_SETUP;
                  t_start = 1'b1;
                  t_kind  = ACT_LOAD_PC;
               end
            end else begin
               latch_hi = 1'b1;
               state_d  = src.byte_last ? ERROR : GET_LO;
            end
         end
         GET_LO: if (take) begin
            if (is_leader || is_origin) begin
               state_d = ERROR;
            end else begin
               latch_lo = 1'b1;
               state_d  = SETUP;
               t_start  = 1'b1;
               t_kind   = origin_q ? ACT_LOAD_PC : ACT_DEPOSIT;
            end
         end
         SETUP:  if (t_phase_end) state_d = STROBE;
         STROBE: if (t_phase_end) state_d = RELEASE;
         RELEASE: if (t_finished) begin
            bump = !origin_q;
            if (last_q) begin
               state_d = LAST_SETUP;
               t_start = 1'b1;
               t_kind  = ACT_LOAD_PC;
            end else begin
               state_d = GET_HI;
            end
         end
         LAST_SETUP:  if (t_phase_end) state_d = LAST_STROBE;
         LAST_STROBE: if (t_phase_end) state_d = LAST_RELEASE;
         LAST_RELEASE: if (t_finished) begin
            state_d = RUN_WAIT;
            t_start = 1'b1;
            t_kind  = ACT_WAIT;
         end
         RUN_WAIT: if (t_finished) state_d = DONE;
         DONE:     state_d = DONE;
         ERROR:    state_d = ERROR;
         default:  state_d = IDLE;
      endcase
   end

   // State, word holding registers and saturating deposit counter
   always_ff @(posedge clk or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         origin_q <= 1'b0;
         last_q   <= 1'b0;
         words_q  <= '0;
      end else begin
         state_q <= state_d;
         if (latch_hi) begin
            hi_q     <= byte_half;
            origin_q <= is_origin;
         end
         if (latch_lo) begin
            lo_q   <= byte_half;
            last_q <= src.byte_last;
         end
         if (bump && (words_q != '1)) words_q <= words_q + 1'b1;
      end
   end

   // Panel switch value and status outputs decoded from state
   always_comb begin
      sw    = '0;
      run   = 1'b0;
      done  = 1'b0;
      error = 1'b0;
      busy  = 1'b1;
      case (state_q)
         SETUP, STROBE, RELEASE:                         sw = {hi_q, lo_q};
         LAST_SETUP, LAST_STROBE, LAST_RELEASE, RUN_WAIT: sw = START_PC;
         DONE: begin
            sw   = START_PC;
            run  = 1'b1;
            done = 1'b1;
            busy = 1'b0;
         end
         ERROR: begin
            error = 1'b1;
            busy  = 1'b0;
         end
         IDLE:    busy = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_panel_loader.sv
// Directed bench for panel_loader: one instance at HOLD_CYC=10, one at HOLD_CYC=1.
module tb_panel_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0_n = 1'b0;
   logic rst1_n = 1'b0;

   panel_loader_if bus0 ();
   panel_loader_if bus1 ();

   logic [11:0] sw0, sw1;
   logic        lpc0, dep0, run0, busy0, done0, err0;
   logic        lpc1, dep1, run1, busy1, done1, err1;
   logic [15:0] wl0, wl1;

   panel_loader #(.WORD_W(12), .HOLD_CYC(10), .START_PC(12'o200), .CNT_W(16)) dut0 (
      .clk(clk), .btnCpuReset(rst0_n), .src(bus0), .sw(sw0), .load_pc(lpc0),
      .deposit(dep0), .run(run0), .busy(busy0), .done(done0), .error(err0),
      .words_loaded(wl0)
   );

   panel_loader #(.WORD_W(12), .HOLD_CYC(1), .START_PC(12'o200), .CNT_W(16)) dut1 (
      .clk(clk), .btnCpuReset(rst1_n), .src(bus1), .sw(sw1), .load_pc(lpc1),
      .deposit(dep1), .run(run1), .busy(busy1), .done(done1), .error(err1),
      .words_loaded(wl1)
   );

   int vectors = 0;
   int miscompares = 0;

   // Strobe event log {is_load_pc, sw at rising edge} and rule-violation counters
   logic [12:0] ev0[$];
   logic [12:0] ev1[$];
   int          viol0 = 0, viol1 = 0;
   logic        plpc0 = 1'b0, pdep0 = 1'b0, plpc1 = 1'b0, pdep1 = 1'b0;
   logic [11:0] psw0 = '0, psw1 = '0;

   // Record strobe rises; flag overlapping strobes or sw moving under a strobe
   always @(negedge clk) begin
      if (lpc0 && !plpc0) ev0.push_back({1'b1, sw0});
      if (dep0 && !pdep0) ev0.push_back({1'b0, sw0});
      if ((lpc0 && dep0) || ((lpc0 || dep0) && (sw0 !== psw0))) viol0 <= viol0 + 1;
      plpc0 <= lpc0;
      pdep0 <= dep0;
      psw0  <= sw0;
   end

   // Same recorder for the HOLD_CYC=1 instance
   always @(negedge clk) begin
      if (lpc1 && !plpc1) ev1.push_back({1'b1, sw1});
      if (dep1 && !pdep1) ev1.push_back({1'b0, sw1});
      if ((lpc1 && dep1) || ((lpc1 || dep1) && (sw1 !== psw1))) viol1 <= viol1 + 1;
      plpc1 <= lpc1;
      pdep1 <= dep1;
      psw1  <= sw1;
   end

   initial begin
      bus0.byte_valid = 1'b0; bus0.byte_data = '0; bus0.byte_last = 1'b0;
      bus1.byte_valid = 1'b0; bus1.byte_data = '0; bus1.byte_last = 1'b0;
   end

   // Offer one byte and wait (bounded) for it to be taken; returns at posedge+1
   task automatic send_byte(input int unsigned u, input logic [7:0] d, input logic l);
      bit   got;
      logic rdy;
      got = 1'b0;
      if (u == 0) begin bus0.byte_valid = 1'b1; bus0.byte_data = d; bus0.byte_last = l; end
      else        begin bus1.byte_valid = 1'b1; bus1.byte_data = d; bus1.byte_last = l; end
      for (int i = 0; i < 400 && !got; i++) begin
         rdy = (u == 0) ? bus0.byte_ready : bus1.byte_ready;
         if (rdy) got = 1'b1;
         @(posedge clk); #1;
      end
      if (u == 0) bus0.byte_valid = 1'b0; else bus1.byte_valid = 1'b0;
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL send_byte dut%0d byte %h: byte_ready got 0, expected 1 within 400 cycles", u, d);
      end
   endtask

   task automatic wait_done(input int unsigned u);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         if ((u == 0) ? done0 : done1) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL wait_done dut%0d: done got 0, expected 1 within 1000 cycles", u);
      end
   endtask

   task automatic do_reset(input int unsigned u);
      if (u == 0) rst0_n = 1'b0; else rst1_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (u == 0) rst0_n = 1'b1; else rst1_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({sw0, lpc0, dep0, run0} !== 15'd0) begin
         miscompares++; $display("FAIL reset_panel0: got %h, expected 0", {sw0, lpc0, dep0, run0});
      end
      vectors++;
      if ({busy0, done0, err0, bus0.byte_ready, wl0} !== 20'd0) begin
         miscompares++; $display("FAIL reset_status0: got %h, expected 0", {busy0, done0, err0, bus0.byte_ready, wl0});
      end
      vectors++;
      if ({sw1, lpc1, dep1, run1, busy1, done1, err1, bus1.byte_ready, wl1} !== 35'd0) begin
         miscompares++; $display("FAIL reset_all1: got %h, expected 0", {sw1, lpc1, dep1, run1, busy1, done1, err1, bus1.byte_ready, wl1});
      end
      @(posedge clk); #1;
      rst0_n = 1'b1;
      #1;
      vectors++;
      if ({busy0, bus0.byte_ready} !== 2'b00) begin
         miscompares++; $display("FAIL reset_release_idle: busy/ready got %b, expected 00", {busy0, bus0.byte_ready});
      end
      @(posedge clk); #1;
      vectors++;
      if ({busy0, bus0.byte_ready} !== 2'b11) begin
         miscompares++; $display("FAIL reset_first_get_hi: busy/ready got %b, expected 11", {busy0, bus0.byte_ready});
      end
   endtask

   task automatic test_stream();
      int base, vbase;
      logic [12:0] exp_ev[3];
      exp_ev[0] = {1'b1, 12'o0200};
      exp_ev[1] = {1'b0, 12'o7777};
      exp_ev[2] = {1'b1, 12'o0200};
      do_reset(0);
      base = ev0.size(); vbase = viol0;
      send_byte(0, 8'h80, 1'b0);
      send_byte(0, 8'h80, 1'b0);
      send_byte(0, 8'h42, 1'b0);
      send_byte(0, 8'h00, 1'b0);
      send_byte(0, 8'h3F, 1'b0);
      send_byte(0, 8'h3F, 1'b1);
      wait_done(0);
      vectors++;
      if (ev0.size() - base != 3) begin
         miscompares++; $display("FAIL stream_events: got %0d strobes, expected 3", ev0.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ev0[base + i] !== exp_ev[i]) begin
               miscompares++; $display("FAIL stream_event%0d: got %o, expected %o", i, ev0[base + i], exp_ev[i]);
            end
         end
      end
      vectors++;
      if ({run0, done0, busy0, err0, bus0.byte_ready} !== 5'b11000) begin
         miscompares++; $display("FAIL stream_status: run/done/busy/err/ready got %b, expected 11000", {run0, done0, busy0, err0, bus0.byte_ready});
      end
      vectors++;
      if (wl0 !== 16'd1) begin
         miscompares++; $display("FAIL stream_words: got %0d, expected 1", wl0);
      end
      vectors++;
      if (viol0 != vbase) begin
         miscompares++; $display("FAIL stream_strobe_rules: got %0d violations, expected 0", viol0 - vbase);
      end
   endtask

   task automatic test_timing();
      int dep_cyc, dep_first, sw_ok, rdy_at, run_at, lpc_cyc;
      do_reset(0);
      send_byte(0, 8'h01, 1'b0);
      send_byte(0, 8'h23, 1'b0);
      dep_cyc = 0; dep_first = -1; sw_ok = 0; rdy_at = -1;
      for (int k = 0; k <= 31; k++) begin
         if (k < 30 && sw0 === 12'o0143) sw_ok++;
         if (dep0) begin dep_cyc++; if (dep_first < 0) dep_first = k; end
         if (rdy_at < 0 && bus0.byte_ready) rdy_at = k;
         @(posedge clk); #1;
      end
      vectors++;
      if (dep_cyc != 10) begin
         miscompares++; $display("FAIL timing_deposit_width: got %0d cycles, expected 10", dep_cyc);
      end
      vectors++;
      if (dep_first != 10) begin
         miscompares++; $display("FAIL timing_deposit_start: got cycle %0d, expected 10", dep_first);
      end
      vectors++;
      if (sw_ok != 30) begin
         miscompares++; $display("FAIL timing_sw_stable: got %0d cycles at 0143, expected 30", sw_ok);
      end
      vectors++;
      if (rdy_at != 30) begin
         miscompares++; $display("FAIL timing_next_ready: got cycle %0d, expected 30", rdy_at);
      end
      send_byte(0, 8'h80, 1'b1);
      run_at = -1; lpc_cyc = 0;
      for (int k = 0; k <= 41; k++) begin
         if (run_at < 0 && run0) run_at = k;
         if (lpc0) lpc_cyc++;
         @(posedge clk); #1;
      end
      vectors++;
      if (run_at != 40) begin
         miscompares++; $display("FAIL timing_run_rise: got cycle %0d, expected 40", run_at);
      end
      vectors++;
      if (lpc_cyc != 10) begin
         miscompares++; $display("FAIL timing_start_pc_strobe: got %0d cycles, expected 10", lpc_cyc);
      end
      vectors++;
      if (wl0 !== 16'd1) begin
         miscompares++; $display("FAIL timing_words: got %0d, expected 1", wl0);
      end
   endtask

   task automatic test_error();
      int base;
      do_reset(0);
      base = ev0.size();
      send_byte(0, 8'h01, 1'b0);
      send_byte(0, 8'h45, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      vectors++;
      if ({err0, busy0, run0, done0, bus0.byte_ready} !== 5'b10000) begin
         miscompares++; $display("FAIL error_lo_class: err/busy/run/done/ready got %b, expected 10000", {err0, busy0, run0, done0, bus0.byte_ready});
      end
      vectors++;
      if (ev0.size() != base || wl0 !== 16'd0) begin
         miscompares++; $display("FAIL error_no_strobe: got %0d strobes words %0d, expected 0 and 0", ev0.size() - base, wl0);
      end
      do_reset(0);
      send_byte(0, 8'h05, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({err0, run0, lpc0, dep0} !== 4'b1000) begin
         miscompares++; $display("FAIL error_last_on_hi: err/run/lpc/dep got %b, expected 1000", {err0, run0, lpc0, dep0});
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int base;
      do_reset(0);
      send_byte(0, 8'h3F, 1'b0);
      send_byte(0, 8'h3F, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (dep0) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      vectors++;
      if (!seen) begin
         miscompares++; $display("FAIL midreset_reach_strobe: deposit got 0, expected 1");
      end
      rst0_n = 1'b0;
      #1;
      vectors++;
      if ({sw0, lpc0, dep0, run0, busy0, done0, err0, bus0.byte_ready, wl0} !== 35'd0) begin
         miscompares++; $display("FAIL midreset_async_clear: got %h, expected 0", {sw0, lpc0, dep0, run0, busy0, done0, err0, bus0.byte_ready, wl0});
      end
      @(posedge clk); #1;
      rst0_n = 1'b1;
      @(posedge clk); #1;
      base = ev0.size();
      send_byte(0, 8'h3F, 1'b0);
      send_byte(0, 8'h3F, 1'b0);
      send_byte(0, 8'h80, 1'b1);
      wait_done(0);
      vectors++;
      if (ev0.size() - base != 2 || ev0[base] !== {1'b0, 12'o7777} || ev0[base + 1] !== {1'b1, 12'o0200}) begin
         miscompares++; $display("FAIL midreset_reload: got %0d strobes, expected deposit 7777 then load_pc 0200", ev0.size() - base);
      end
      vectors++;
      if (wl0 !== 16'd1 || run0 !== 1'b1) begin
         miscompares++; $display("FAIL midreset_words_run: words %0d run %b, expected 1 and 1", wl0, run0);
      end
   endtask

   task automatic test_leader_only();
      int base;
      do_reset(0);
      base = ev0.size();
      send_byte(0, 8'h80, 1'b0);
      send_byte(0, 8'h80, 1'b0);
      send_byte(0, 8'h80, 1'b1);
      wait_done(0);
      vectors++;
      if (ev0.size() - base != 1 || ev0[base] !== {1'b1, 12'o0200}) begin
         miscompares++; $display("FAIL leader_only_events: got %0d strobes, expected one load_pc 0200", ev0.size() - base);
      end
      vectors++;
      if (wl0 !== 16'd0 || run0 !== 1'b1) begin
         miscompares++; $display("FAIL leader_only_status: words %0d run %b, expected 0 and 1", wl0, run0);
      end
   endtask

   task automatic test_back_to_back();
      int base, vbase;
      logic [12:0] exp_ev[4];
      exp_ev[0] = {1'b0, 12'o0102};
      exp_ev[1] = {1'b0, 12'o7700};
      exp_ev[2] = {1'b0, 12'o0077};
      exp_ev[3] = {1'b1, 12'o0200};
      do_reset(1);
      base = ev1.size(); vbase = viol1;
      send_byte(1, 8'h01, 1'b0); @(posedge clk); #1;
      send_byte(1, 8'h02, 1'b0); @(posedge clk); #1;
      send_byte(1, 8'h3F, 1'b0); @(posedge clk); #1;
      send_byte(1, 8'h00, 1'b0); @(posedge clk); #1;
      send_byte(1, 8'h00, 1'b0); @(posedge clk); #1;
      send_byte(1, 8'h3F, 1'b1);
      wait_done(1);
      vectors++;
      if (ev1.size() - base != 4) begin
         miscompares++; $display("FAIL b2b_events: got %0d strobes, expected 4", ev1.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ev1[base + i] !== exp_ev[i]) begin
               miscompares++; $display("FAIL b2b_event%0d: got %o, expected %o", i, ev1[base + i], exp_ev[i]);
            end
         end
      end
      vectors++;
      if (wl1 !== 16'd3) begin
         miscompares++; $display("FAIL b2b_words: got %0d, expected 3", wl1);
      end
      vectors++;
      if (viol1 != vbase) begin
         miscompares++; $display("FAIL b2b_strobe_rules: got %0d violations, expected 0", viol1 - vbase);
      end
      vectors++;
      if ({run1, err1} !== 2'b10) begin
         miscompares++; $display("FAIL b2b_run: run/err got %b, expected 10", {run1, err1});
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_timing();
      test_error();
      test_reset_mid();
      test_leader_only();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
